// File: rtl/spi_oled_pkg.sv
// spi_oled_pkg: shared encodings for the OLED SPI path (MOSI buffer and serializer).
package spi_oled_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;
    localparam logic OLED_DC_CMD  = 1'b0;
    localparam logic OLED_DC_DATA = 1'b1;
    localparam int   SPI_WIDTH    = 8;
endpackage

// File: rtl/spi_cs_timer.sv
// spi_cs_timer: 4-bit loadable down-counter that parks at zero; times CS setup and hold.
module spi_cs_timer (
    input  logic       i_SCK,
    input  logic       i_RST,
    input  logic       i_LOAD,
    input  logic [3:0] i_VAL,
    output logic       o_ZERO
);
    logic [3:0] r_cnt;
    always_ff @(posedge i_SCK or posedge i_RST) begin
        if (i_RST)
            r_cnt <= 4'd0;
        else if (i_LOAD)
            r_cnt <= i_VAL;
        else if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
    end
    assign o_ZERO = (r_cnt == 4'd0);
endmodule

// File: rtl/spi_mosi_serializer.sv
// spi_mosi_serializer: shifts buffered bytes MSB-first onto MOSI with CS_N/DC framing,
// flagging the second-to-last bit so the next byte can follow without a gap.
module spi_mosi_serializer
    import spi_oled_pkg::*;
#(
    parameter int WIDTH    = SPI_WIDTH,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1
) (
    input  logic             i_SCK,
    input  logic             i_RST,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic             i_DC,
    input  logic             i_START,
    output logic             o_MOSI,
    output logic             o_CS_N,
    output logic             o_DC,
    output logic             o_SCLK_EN,
    output logic             o_FINAL_BIT,
    output logic             o_BYTE_DONE,
    output logic             o_BUSY,
    output logic [7:0]       o_BYTE_CNT
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(WIDTH - 1);
    localparam logic [3:0]      SETUP_LD = 4'(CS_SETUP > 0 ? CS_SETUP - 1 : 0);
    localparam logic [3:0]      HOLD_LD  = 4'(CS_HOLD > 0 ? CS_HOLD - 1 : 0);
    spi_state_t       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_cs_n;
    logic             r_dc;
    logic [7:0]       r_byte_cnt;
    logic             w_last;
    logic             w_tmr_load;
    logic [3:0]       w_tmr_val;
    logic             w_tmr_zero;
    assign w_last     = (r_state == ST_SHIFT) && (r_cnt == '0);
    assign w_tmr_load = ((r_state == ST_IDLE) && i_START) || (w_last && !i_START);
    assign w_tmr_val  = (r_state == ST_IDLE) ? SETUP_LD : HOLD_LD;
    spi_cs_timer u_cs_timer (
        .i_SCK  (i_SCK),
        .i_RST  (i_RST),
        .i_LOAD (w_tmr_load),
        .i_VAL  (w_tmr_val),
        .o_ZERO (w_tmr_zero)
    );
    always_ff @(posedge i_SCK or posedge i_RST) begin
        if (i_RST) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_cs_n     <= 1'b1;
            r_dc       <= 1'b0;
            r_byte_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_START) begin
                        r_shreg    <= i_DATA;
                        r_dc       <= i_DC;
                        r_cnt      <= CNT_MAX;
                        r_cs_n     <= 1'b0;
                        r_byte_cnt <= 8'd0;
                        r_state    <= (CS_SETUP == 0) ? ST_SHIFT : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tmr_zero)
                        r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_byte_cnt <= r_byte_cnt + {7'd0, r_byte_cnt != 8'hFF};
                        // Byte boundary: chain the next byte or close the frame
                        if (i_START) begin
                            r_shreg <= i_DATA;
                            r_dc    <= i_DC;
                            r_cnt   <= CNT_MAX;
                        end else if (CS_HOLD == 0) begin
                            r_state <= ST_IDLE;
                            r_cs_n  <= 1'b1;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tmr_zero) begin
                        r_state <= ST_IDLE;
                        r_cs_n  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign o_MOSI      = (r_state == ST_SHIFT) && r_shreg[WIDTH-1];
    assign o_SCLK_EN   = (r_state == ST_SHIFT);
    assign o_FINAL_BIT = (r_state == ST_SHIFT) && (r_cnt == CW'(1));
    assign o_BYTE_DONE = w_last;
    assign o_BUSY      = (r_state != ST_IDLE);
    assign o_CS_N      = r_cs_n;
    assign o_DC        = r_dc;
    assign o_BYTE_CNT  = r_byte_cnt;
endmodule

// File: tb/tb_spi_mosi_serializer.sv
// tb_spi_mosi_serializer: two serializers (setup/hold 1/1 and 0/0) checked cycle by cycle
// against a frame-level waveform model built from the byte list.
module tb_spi_mosi_serializer;
    localparam int W = 8;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       dc;
    logic       start;
    bit         sel;
    logic       a_mosi, a_cs_n, a_dc, a_sclk, a_fin, a_done, a_busy;
    logic [7:0] a_cnt;
    logic       b_mosi, b_cs_n, b_dc, b_sclk, b_fin, b_done, b_busy;
    logic [7:0] b_cnt;
    always #5 clk = ~clk;
    spi_mosi_serializer #(.WIDTH(W), .CS_SETUP(1), .CS_HOLD(1)) dut_a (
        .i_SCK(clk), .i_RST(rst), .i_DATA(data), .i_DC(dc), .i_START(start),
        .o_MOSI(a_mosi), .o_CS_N(a_cs_n), .o_DC(a_dc), .o_SCLK_EN(a_sclk),
        .o_FINAL_BIT(a_fin), .o_BYTE_DONE(a_done), .o_BUSY(a_busy), .o_BYTE_CNT(a_cnt)
    );
    spi_mosi_serializer #(.WIDTH(W), .CS_SETUP(0), .CS_HOLD(0)) dut_b (
        .i_SCK(clk), .i_RST(rst), .i_DATA(data), .i_DC(dc), .i_START(start),
        .o_MOSI(b_mosi), .o_CS_N(b_cs_n), .o_DC(b_dc), .o_SCLK_EN(b_sclk),
        .o_FINAL_BIT(b_fin), .o_BYTE_DONE(b_done), .o_BUSY(b_busy), .o_BYTE_CNT(b_cnt)
    );
    typedef struct {
        logic       mosi, cs_n, dc, sclk, fin, done, busy;
        logic [7:0] cnt;
        int         k;
        bit         hold;
    } exp_t;
    typedef struct {
        logic [7:0] d;
        logic       dc;
        bit         s;
        int         first_sclk;
        int         busy;
        int         sclk;
    } vec_t;
    localparam logic [14:0] RST_VEC = 15'b0_1_0_0_0_0_0_00000000;
    exp_t       exp_q[$];
    logic [7:0] tx_data[0:299];
    logic       tx_dc[0:299];
    vec_t       tbl[4];
    int         n_cmp = 0, n_bad = 0;
    int         busy_cycles, sclk_cycles, first_sclk;
    function automatic logic [14:0] outs_a();
        return {a_mosi, a_cs_n, a_dc, a_sclk, a_fin, a_done, a_busy, a_cnt};
    endfunction
    function automatic logic [14:0] outs_b();
        return {b_mosi, b_cs_n, b_dc, b_sclk, b_fin, b_done, b_busy, b_cnt};
    endfunction
    function automatic logic [14:0] pack(exp_t e);
        return {e.mosi, e.cs_n, e.dc, e.sclk, e.fin, e.done, e.busy, e.cnt};
    endfunction
    function automatic logic [7:0] sat(int v);
        return 8'(v > 255 ? 255 : v);
    endfunction
    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask
    // Whole-frame waveform: setup cycles, W bits per byte, hold cycles, one idle cycle
    function automatic void build(int n, int su, int ho);
        exp_t e;
        exp_q.delete();
        for (int s = 0; s < su; s++) begin
            e = '{1'b0, 1'b0, tx_dc[0], 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, -1, 1'b0};
            exp_q.push_back(e);
        end
        for (int k = 0; k < n; k++)
            for (int i = 0; i < W; i++) begin
                e = '{tx_data[k][W-1-i], 1'b0, tx_dc[k], 1'b1, i == W - 2, i == W - 1,
                      1'b1, sat(k), k, 1'b0};
                exp_q.push_back(e);
            end
        for (int h = 0; h < ho; h++) begin
            e = '{1'b0, 1'b0, tx_dc[n-1], 1'b0, 1'b0, 1'b0, 1'b1, sat(n), -1, 1'b1};
            exp_q.push_back(e);
        end
        e = '{1'b0, 1'b1, tx_dc[n-1], 1'b0, 1'b0, 1'b0, 1'b0, sat(n), -1, 1'b0};
        exp_q.push_back(e);
    endfunction
    task automatic idle_gap(int m);
        start = 1'b0;
        repeat (m) @(negedge clk);
    endtask
    // Acts as the MOSI buffer: new byte (or START drop) on the final-bit edge
    task automatic run_txn(int n, bit s, bit keep);
        logic [14:0] o;
        sel = s;
        build(n, s ? 0 : 1, s ? 0 : 1);
        data  = tx_data[0];
        dc    = tx_dc[0];
        start = 1'b1;
        busy_cycles = 0;
        sclk_cycles = 0;
        first_sclk  = -1;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            o = sel ? outs_b() : outs_a();
            check($sformatf("cycle%0d_byte%0d", c, exp_q[c].k), {17'd0, o}, {17'd0, pack(exp_q[c])});
            if (o[8]) busy_cycles++;
            if (o[11]) begin
                if (first_sclk < 0) first_sclk = c;
                sclk_cycles++;
            end
            if (exp_q[c].fin) begin
                if (exp_q[c].k < n - 1) begin
                    data = tx_data[exp_q[c].k + 1];
                    dc   = tx_dc[exp_q[c].k + 1];
                end else begin
                    start = 1'b0;
                end
            end
            if (exp_q[c].hold && keep) start = 1'b1;
        end
    endtask
    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1, 10, 8};
        tbl[1] = '{8'h01, 1'b1, 1'b1, 0, 8, 8};
        tbl[2] = '{8'h5A, 1'b1, 1'b0, 1, 10, 8};
        tbl[3] = '{8'h80, 1'b0, 1'b1, 0, 8, 8};
        rst = 1'b1; start = 1'b0; data = 8'h00; dc = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", {17'd0, outs_a()}, {17'd0, RST_VEC});
        check("reset_b", {17'd0, outs_b()}, {17'd0, RST_VEC});
        rst = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            idle_gap(12);
            tx_data[0] = tbl[t].d;
            tx_dc[0]   = tbl[t].dc;
            run_txn(1, tbl[t].s, 1'b0);
            check($sformatf("tbl%0d_first_sclk", t), 32'(first_sclk), 32'(tbl[t].first_sclk));
            check($sformatf("tbl%0d_busy", t), 32'(busy_cycles), 32'(tbl[t].busy));
            check($sformatf("tbl%0d_sclk", t), 32'(sclk_cycles), 32'(tbl[t].sclk));
        end
        idle_gap(12);
        tx_data[0] = 8'h3C; tx_dc[0] = 1'b1;
        tx_data[1] = 8'hFF; tx_dc[1] = 1'b0;
        run_txn(2, 1'b0, 1'b0);
        check("b2b_sclk", 32'(sclk_cycles), 32'd16);
        check("b2b_cnt", {24'd0, a_cnt}, 32'd2);
        idle_gap(12);
        tx_data[0] = 8'hC3; tx_dc[0] = 1'b0;
        run_txn(1, 1'b0, 1'b1);
        tx_data[0] = 8'h96; tx_dc[0] = 1'b1;
        run_txn(1, 1'b0, 1'b0);
        idle_gap(12);
        sel = 1'b0; data = 8'h81; dc = 1'b1; start = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_sclk", {31'd0, a_sclk}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_a", {17'd0, outs_a()}, {17'd0, RST_VEC});
        check("rst_mid_b", {17'd0, outs_b()}, {17'd0, RST_VEC});
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d", i), {17'd0, outs_a()}, {17'd0, RST_VEC});
        end
        for (int r = 0; r < 20; r++) begin
            int n;
            bit s;
            n = $urandom_range(1, 4);
            s = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                tx_data[k] = 8'($urandom);
                tx_dc[k]   = 1'($urandom);
            end
            idle_gap(12);
            run_txn(n, s, 1'b0);
        end
        for (int k = 0; k < 300; k++) begin
            tx_data[k] = 8'($urandom);
            tx_dc[k]   = 1'($urandom);
        end
        idle_gap(12);
        run_txn(300, 1'b0, 1'b0);
        check("sat_cnt", {24'd0, a_cnt}, 32'd255);
        check("sat_sclk", 32'(sclk_cycles), 32'd2400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
